// File: rtl/simd_pkg.sv
// Shared types and default parameters for the SIMD address generator.
// Consumed by the generator top and its per-loop product term.
package simd_pkg;

  localparam int DEF_LOOP_ID_W   = 5;
  localparam int DEF_LOOP_ITER_W = 16;
  localparam int DEF_STRIDE_W    = 32;
  localparam int DEF_ADDR_W      = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/simd_addr_term.sv
// One loop's contribution: zero-extended iteration times sign-extended
// stride, truncated to the address width and registered (stage 1).
module simd_addr_term
  import simd_pkg::*;
#(
  parameter int LOOP_ITER_W = DEF_LOOP_ITER_W,
  parameter int STRIDE_W    = DEF_STRIDE_W,
  parameter int ADDR_W      = DEF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [LOOP_ITER_W-1:0] iter,
  input  logic [STRIDE_W-1:0]    stride,
  output logic [ADDR_W-1:0]      term
);

  logic [ADDR_W-1:0] iter_x;
  logic [ADDR_W-1:0] stride_x;

  // Low ADDR_W bits of the product are exact modulo 2^ADDR_W.
  assign iter_x   = ADDR_W'(iter);
  assign stride_x = ADDR_W'($signed(stride));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      term <= '0;
    end else if (en) begin
      term <= iter_x * stride_x;
    end
  end

endmodule

// File: rtl/simd_addr_gen.sv
// Strided SIMD address generator: base + sum(iter[l] * stride[l]),
// two-stage pipeline with stall, tile FSM and sticky config error.
module simd_addr_gen
  import simd_pkg::*;
#(
  parameter int LOOP_ID_W   = DEF_LOOP_ID_W,
  parameter int LOOP_ITER_W = DEF_LOOP_ITER_W,
  parameter int STRIDE_W    = DEF_STRIDE_W,
  parameter int ADDR_W      = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 block_done,
  input  logic                 cfg_base_addr_v,
  input  logic [ADDR_W-1:0]    cfg_base_addr,
  input  logic                 cfg_loop_stride_v,
  input  logic [STRIDE_W-1:0]  cfg_loop_stride,
  input  logic [LOOP_ID_W-1:0] cfg_loop_stride_loop_id,
  input  logic                 iter_v,
  input  logic                 iter_last,
  input  logic [LOOP_ITER_W*(1<<LOOP_ID_W)-1:0] current_iters,
  output logic                 addr_v,
  output logic [ADDR_W-1:0]    addr,
  output logic                 addr_last,
  output logic                 busy,
  output logic                 cfg_err
);

  localparam int NUM_MAX_LOOPS = 1 << LOOP_ID_W;

  state_t state;
  state_t state_nx;

  logic [ADDR_W-1:0]   base;
  logic [STRIDE_W-1:0] stride [NUM_MAX_LOOPS];
  logic [NUM_MAX_LOOPS-1:0][ADDR_W-1:0] terms;
  logic [ADDR_W-1:0]   sum;
  logic                acc;
  logic                idle;
  logic                cfg_wr;
  logic                s1_v;
  logic                s1_last;

  assign idle   = (state == IDLE);
  assign acc    = iter_v & ~stall & (state == RUN);
  assign cfg_wr = cfg_base_addr_v | cfg_loop_stride_v;
  assign busy   = ~idle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (acc & iter_last) state_nx = DRAIN;
      DRAIN:   if (addr_v & addr_last & ~stall) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Config is only writable between tiles; anything else is flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base    <= '0;
      cfg_err <= 1'b0;
      for (int l = 0; l < NUM_MAX_LOOPS; l++) stride[l] <= '0;
    end else if (idle) begin
      if (block_done) begin
        base    <= '0;
        cfg_err <= 1'b0;
        for (int l = 0; l < NUM_MAX_LOOPS; l++) stride[l] <= '0;
      end else begin
        if (cfg_base_addr_v) base <= cfg_base_addr;
        if (cfg_loop_stride_v) begin
          stride[cfg_loop_stride_loop_id] <= cfg_loop_stride;
        end
      end
    end else if (cfg_wr | block_done) begin
      cfg_err <= 1'b1;
    end
  end

  for (genvar l = 0; l < NUM_MAX_LOOPS; l++) begin : g_term
    simd_addr_term #(
      .LOOP_ITER_W(LOOP_ITER_W),
      .STRIDE_W   (STRIDE_W),
      .ADDR_W     (ADDR_W)
    ) u_term (
      .clk   (clk),
      .reset (reset),
      .en    (acc),
      .iter  (current_iters[LOOP_ITER_W*l +: LOOP_ITER_W]),
      .stride(stride[l]),
      .term  (terms[l])
    );
  end

  always_comb begin
    sum = '0;
    for (int l = 0; l < NUM_MAX_LOOPS; l++) sum = sum + terms[l];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v      <= 1'b0;
      s1_last   <= 1'b0;
      addr_v    <= 1'b0;
      addr_last <= 1'b0;
      addr      <= '0;
    end else if (~stall) begin
      s1_v      <= acc;
      s1_last   <= acc & iter_last;
      addr_v    <= s1_v;
      addr_last <= s1_v & s1_last;
      if (s1_v) addr <= base + sum;
    end
  end

endmodule

// File: tb/tb_simd_addr_gen.sv
// Randomized bench for simd_addr_gen against a queue-based reference
// model, plus directed cases with hand-computed addresses.
module tb_simd_addr_gen;

  localparam int NL = 32;
  localparam int IW = 16;
  localparam int SW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic stall;
  logic block_done;
  logic cfg_base_addr_v;
  logic [AW-1:0] cfg_base_addr;
  logic cfg_loop_stride_v;
  logic [SW-1:0] cfg_loop_stride;
  logic [4:0] cfg_loop_stride_loop_id;
  logic iter_v;
  logic iter_last;
  logic [IW*NL-1:0] current_iters;
  logic addr_v;
  logic [AW-1:0] addr;
  logic addr_last;
  logic busy;
  logic cfg_err;

  always #5 clk = ~clk;

  simd_addr_gen dut (
    .clk                    (clk),
    .reset                  (reset),
    .start                  (start),
    .stall                  (stall),
    .block_done             (block_done),
    .cfg_base_addr_v        (cfg_base_addr_v),
    .cfg_base_addr          (cfg_base_addr),
    .cfg_loop_stride_v      (cfg_loop_stride_v),
    .cfg_loop_stride        (cfg_loop_stride),
    .cfg_loop_stride_loop_id(cfg_loop_stride_loop_id),
    .iter_v                 (iter_v),
    .iter_last              (iter_last),
    .current_iters          (current_iters),
    .addr_v                 (addr_v),
    .addr                   (addr),
    .addr_last              (addr_last),
    .busy                   (busy),
    .cfg_err                (cfg_err)
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  // Reference model: 0=idle, 1=run, 2=drain
  typedef struct {
    logic [31:0] a;
    bit last;
  } beat_t;

  int m_state;
  logic [31:0] m_base;
  logic [31:0] m_stride [NL];
  bit m_err;
  beat_t pipe [$];
  bit e_v;
  bit e_last;
  logic [31:0] e_addr;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_addr(logic [IW*NL-1:0] it);
    longint s;
    s = longint'(m_base);
    for (int l = 0; l < NL; l++) begin
      s += longint'(it[IW*l +: IW]) * longint'($signed(m_stride[l]));
    end
    return s[31:0];
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_base = '0;
    m_err = 0;
    for (int l = 0; l < NL; l++) m_stride[l] = '0;
    pipe.delete();
    e_v = 0;
    e_last = 0;
    e_addr = '0;
  endtask

  task automatic model_edge();
    bit acc;
    bit drain_done;
    beat_t b;
    if (reset) begin
      model_reset();
      return;
    end
    acc = iter_v && !stall && m_state == 1;
    drain_done = e_v && e_last && !stall;
    if (!stall) begin
      if (pipe.size() > 0) begin
        b = pipe.pop_front();
        e_v = 1;
        e_addr = b.a;
        e_last = b.last;
      end else begin
        e_v = 0;
        e_last = 0;
      end
      if (acc) begin
        b.a = model_addr(current_iters);
        b.last = iter_last;
        pipe.push_back(b);
      end
    end
    if (m_state == 0) begin
      if (block_done) begin
        m_base = '0;
        m_err = 0;
        for (int l = 0; l < NL; l++) m_stride[l] = '0;
      end else begin
        if (cfg_base_addr_v) m_base = cfg_base_addr;
        if (cfg_loop_stride_v) m_stride[cfg_loop_stride_loop_id] = cfg_loop_stride;
      end
    end else if (cfg_base_addr_v || cfg_loop_stride_v || block_done) begin
      m_err = 1;
    end
    case (m_state)
      0: if (start) m_state = 1;
      1: if (acc && iter_last) m_state = 2;
      2: if (drain_done) m_state = 0;
      default: m_state = 0;
    endcase
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("addr_v", addr_v, e_v);
      if (e_v) begin
        check("addr", addr, e_addr);
        check("addr_last", addr_last, e_last);
      end
      check("busy", busy, m_state != 0);
      check("cfg_err", cfg_err, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start = 0;
    stall = 0;
    block_done = 0;
    cfg_base_addr_v = 0;
    cfg_base_addr = '0;
    cfg_loop_stride_v = 0;
    cfg_loop_stride = '0;
    cfg_loop_stride_loop_id = '0;
    iter_v = 0;
    iter_last = 0;
    current_iters = '0;
  endtask

  task automatic set_iter(int l, int v);
    current_iters[IW*l +: IW] = IW'(v);
  endtask

  task automatic wait_out(string name, logic [31:0] exp_a, bit exp_last);
    int n = 0;
    while (!addr_v && n < 8) begin
      tick();
      n++;
    end
    if (!addr_v) begin
      total++;
      bad++;
      $display("FAIL %s: timeout addr_v=0 want 1", name);
    end else begin
      check(name, addr, exp_a);
      check({name, "_last"}, addr_last, exp_last);
      check({name, "_model"}, e_addr, exp_a);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int nb;
    int seen;
    idle_inputs();
    reset = 1;
    model_reset();
    tick();
    tick();
    check("rst_addr_v", addr_v, 0);
    check("rst_addr", addr, 0);
    check("rst_last", addr_last, 0);
    check("rst_busy", busy, 0);
    check("rst_err", cfg_err, 0);
    reset = 0;
    chk_en = 1;

    // base + stride0 together, then stride1 alongside start
    cfg_base_addr_v = 1;
    cfg_base_addr = 32'h1000;
    cfg_loop_stride_v = 1;
    cfg_loop_stride_loop_id = 0;
    cfg_loop_stride = 4;
    tick();
    cfg_base_addr_v = 0;
    cfg_loop_stride_loop_id = 1;
    cfg_loop_stride = 64;
    start = 1;
    tick();
    cfg_loop_stride_v = 0;
    start = 0;
    iter_v = 1;
    iter_last = 1;
    set_iter(0, 3);
    set_iter(1, 2);
    tick();
    check("t1_busy_drain", busy, 1);
    set_iter(0, 7);
    iter_last = 0;
    wait_out("t1_addr", 32'h108C, 1);
    iter_v = 0;
    tick();
    check("t1_busy_after", busy, 0);

    // negative stride wrap-around
    block_done = 1;
    tick();
    block_done = 0;
    cfg_base_addr_v = 1;
    cfg_base_addr = 32'h10;
    cfg_loop_stride_v = 1;
    cfg_loop_stride_loop_id = 0;
    cfg_loop_stride = 32'hFFFF_FFFC;
    start = 1;
    tick();
    idle_inputs();
    iter_v = 1;
    iter_last = 1;
    set_iter(0, 5);
    tick();
    iter_v = 0;
    wait_out("t2_wrap", 32'hFFFF_FFFC, 1);
    tick();

    // config write while running is dropped and flagged
    start = 1;
    tick();
    start = 0;
    cfg_loop_stride_v = 1;
    cfg_loop_stride_loop_id = 0;
    cfg_loop_stride = 100;
    tick();
    cfg_loop_stride_v = 0;
    check("t3_err", cfg_err, 1);
    iter_v = 1;
    iter_last = 1;
    current_iters = '0;
    set_iter(0, 1);
    tick();
    iter_v = 0;
    wait_out("t3_keep", 32'h0C, 1);
    tick();
    check("t3_err_hold", cfg_err, 1);
    block_done = 1;
    tick();
    block_done = 0;
    check("t3_err_clr", cfg_err, 0);
    start = 1;
    tick();
    start = 0;
    iter_v = 1;
    iter_last = 1;
    for (int l = 0; l < NL; l++) set_iter(l, $urandom);
    tick();
    iter_v = 0;
    wait_out("t3_cleared", 32'h0, 1);
    tick();

    // stall with both stages full
    idle_inputs();
    cfg_base_addr_v = 1;
    cfg_base_addr = 32'h2000;
    cfg_loop_stride_v = 1;
    cfg_loop_stride_loop_id = 0;
    cfg_loop_stride = 8;
    tick();
    idle_inputs();
    start = 1;
    tick();
    start = 0;
    iter_v = 1;
    set_iter(0, 1);
    tick();
    set_iter(0, 2);
    tick();
    check("t4_pre", addr, 32'h2008);
    set_iter(0, 3);
    iter_last = 1;
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_stall_v", addr_v, 1);
      check("t4_stall_a", addr, 32'h2008);
    end
    stall = 0;
    tick();
    iter_v = 0;
    check("t4_b", addr, 32'h2010);
    tick();
    check("t4_c", addr, 32'h2018);
    check("t4_c_last", addr_last, 1);
    tick();
    check("t4_idle", busy, 0);

    // randomized tiles
    for (int blk = 0; blk < 8; blk++) begin
      idle_inputs();
      block_done = 1;
      tick();
      block_done = 0;
      repeat ($urandom_range(1, 6)) begin
        cfg_base_addr_v = $urandom_range(0, 1);
        cfg_base_addr = $urandom;
        cfg_loop_stride_v = 1;
        cfg_loop_stride_loop_id = ($urandom_range(0, 1) == 1) ?
          5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
        cfg_loop_stride = ($urandom_range(0, 1) == 1) ? $urandom :
          32'h0 - 32'($urandom_range(0, 64));
        iter_v = $urandom_range(0, 1);
        tick();
      end
      cfg_base_addr_v = 0;
      cfg_loop_stride_v = 0;
      iter_v = 0;
      start = 1;
      tick();
      start = 0;
      n = 0;
      nb = $urandom_range(2, 10);
      while (m_state == 1 && n < 300) begin
        iter_v = ($urandom_range(0, 2) != 0);
        stall = ($urandom_range(0, 3) == 0);
        for (int l = 0; l < NL; l++) begin
          set_iter(l, ($urandom_range(0, 2) == 0) ? $urandom : $urandom_range(0, 7));
        end
        iter_last = (n >= nb) && ($urandom_range(0, 1) == 1);
        start = ($urandom_range(0, 7) == 0);
        cfg_loop_stride_v = ($urandom_range(0, 19) == 0);
        cfg_loop_stride_loop_id = 5'($urandom_range(0, 31));
        cfg_loop_stride = $urandom;
        tick();
        n++;
      end
      start = 0;
      cfg_loop_stride_v = 0;
      while (m_state != 0 && n < 400) begin
        iter_v = $urandom_range(0, 1);
        stall = ($urandom_range(0, 3) == 0);
        tick();
        n++;
      end
      if (m_state != 0) begin
        total++;
        bad++;
        $display("FAIL rand_blk%0d: timeout state=%0d want 0", blk, m_state);
      end
    end

    // reset between two accepted beats
    idle_inputs();
    block_done = 1;
    tick();
    block_done = 0;
    cfg_base_addr_v = 1;
    cfg_base_addr = 32'h3000;
    cfg_loop_stride_v = 1;
    cfg_loop_stride_loop_id = 0;
    cfg_loop_stride = 16;
    start = 1;
    tick();
    idle_inputs();
    iter_v = 1;
    set_iter(0, 1);
    tick();
    set_iter(0, 2);
    tick();
    check("t6_pre_v", addr_v, 1);
    check("t6_pre_a", addr, 32'h3010);
    set_iter(0, 3);
    #2;
    reset = 1;
    model_reset();
    #1;
    check("t6_rst_v", addr_v, 0);
    check("t6_rst_a", addr, 0);
    check("t6_rst_busy", busy, 0);
    tick();
    reset = 0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (addr_v) seen++;
    end
    check("t6_no_out", seen, 0);
    start = 1;
    tick();
    start = 0;
    iter_last = 1;
    set_iter(0, 9);
    tick();
    iter_v = 0;
    wait_out("t6_new", 32'h0, 1);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
